// File: rtl/fpu_mul_if.sv
// Operand/result valid-ready bundle between the FPU issue stage, fpu_mul_pipe and writeback.
interface fpu_mul_if #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         invalid;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid
    );
endinterface

// File: rtl/fpu_mul_pipe.sv
// Pipelined floating-point multiplier: RNE rounding, flush-to-zero, saturating overflow.
// Define FPU_MUL_INF_NAN_EN to reserve the all-ones exponent for inf/NaN handling.
module fpu_mul_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input logic      clk,
    input logic      rst_n,
    fpu_mul_if.slave bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned PW   = 2 * (MAN_W + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
`ifdef FPU_MUL_INF_NAN_EN
    localparam int              EMAX     = 2 ** EXP_W - 2;
    localparam logic [MAN_W-1:0] SAT_FRAC = '0;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
`else
    localparam int              EMAX     = 2 ** EXP_W - 1;
    localparam logic [MAN_W-1:0] SAT_FRAC = '1;
`endif

    logic en_o, en3, en2, en1;
    logic v1, v2, v3, out_valid_q;

    // Each stage loads when empty or when its downstream neighbour moves on
    assign en_o         = ~out_valid_q | bus.out_ready;
    assign en3          = ~v3 | en_o;
    assign en2          = ~v2 | en3;
    assign en1          = ~v1 | en2;
    assign bus.in_ready = en1;

    // Operand capture
    logic [W-1:0] a1, b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
        end else if (en1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a1 <= bus.op_a;
                b1 <= bus.op_b;
            end
        end
    end

    // S1: sign, zero detect, mantissa product, biased exponent sum
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [PW-1:0]    s1_prod_c;
    logic [EW-1:0]    s1_e_c;
    assign ea        = a1[W-2 -: EXP_W];
    assign eb        = b1[W-2 -: EXP_W];
    assign fa        = a1[MAN_W-1:0];
    assign fb        = b1[MAN_W-1:0];
    assign s1_prod_c = PW'({1'b1, fa}) * PW'({1'b1, fb});
    assign s1_e_c    = EW'(ea) + EW'(eb) - EW'(BIAS);

    logic          sign2, zero2;
    logic [PW-1:0] prod2;
    logic [EW-1:0] e2;
`ifdef FPU_MUL_INF_NAN_EN
    logic nan2, inf2;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            zero2 <= 1'b0;
            prod2 <= '0;
            e2    <= '0;
`ifdef FPU_MUL_INF_NAN_EN
            nan2  <= 1'b0;
            inf2  <= 1'b0;
`endif
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                sign2 <= a1[W-1] ^ b1[W-1];
                zero2 <= (ea == '0) | (eb == '0);
                prod2 <= s1_prod_c;
                e2    <= s1_e_c;
`ifdef FPU_MUL_INF_NAN_EN
                nan2  <= ((ea == EXP_ONES) & (fa != '0)) | ((eb == EXP_ONES) & (fb != '0));
                inf2  <= ((ea == EXP_ONES) & (fa == '0)) | ((eb == EXP_ONES) & (fb == '0));
`endif
            end
        end
    end

    // S2: normalise by one bit, then round-to-nearest-even on guard/sticky
    logic             norm, g, st, up;
    logic [PW-2:0]    sh;
    logic [MAN_W-1:0] frac_t;
    logic [MAN_W:0]   rnd;
    logic [EW-1:0]    s2_e_c;
    assign norm   = prod2[PW-1];
    assign sh     = norm ? prod2[PW-2:0] : {prod2[PW-3:0], 1'b0};
    assign frac_t = sh[PW-2 -: MAN_W];
    assign g      = sh[PW-2-MAN_W];
    assign st     = |sh[PW-3-MAN_W:0];
    assign up     = g & (st | frac_t[0]);
    assign rnd    = {1'b0, frac_t} + (MAN_W+1)'(up);
    assign s2_e_c = e2 + EW'(norm) + EW'(rnd[MAN_W]);

    logic             sign3, zero3;
    logic [MAN_W-1:0] frac3;
    logic [EW-1:0]    e3;
`ifdef FPU_MUL_INF_NAN_EN
    logic nan3, inf3;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            sign3 <= 1'b0;
            zero3 <= 1'b0;
            frac3 <= '0;
            e3    <= '0;
`ifdef FPU_MUL_INF_NAN_EN
            nan3  <= 1'b0;
            inf3  <= 1'b0;
`endif
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                sign3 <= sign2;
                zero3 <= zero2;
                frac3 <= rnd[MAN_W-1:0];
                e3    <= s2_e_c;
`ifdef FPU_MUL_INF_NAN_EN
                nan3  <= nan2;
                inf3  <= inf2;
`endif
            end
        end
    end

    // S3: special cases, flush-to-zero, saturation, pack
    logic [W-1:0] res_c;
    logic         ovf_c, unf_c;
`ifdef FPU_MUL_INF_NAN_EN
    logic         inv_c;
`endif
    always_comb begin
        res_c      = '0;
        res_c[W-1] = sign3;
        ovf_c      = 1'b0;
        unf_c      = 1'b0;
`ifdef FPU_MUL_INF_NAN_EN
        inv_c      = 1'b0;
        if (nan3 || (inf3 && zero3)) begin
            res_c = QNAN;
            inv_c = ~nan3;
        end else if (inf3) begin
            res_c = {sign3, EXP_ONES, MAN_W'(0)};
        end else
`endif
        if (!zero3) begin
            if (int'($signed(e3)) <= 0) begin
                unf_c = 1'b1;
            end else if (int'($signed(e3)) > EMAX) begin
                ovf_c = 1'b1;
                res_c = {sign3, EXP_ONES, SAT_FRAC};
            end else begin
                res_c = {sign3, e3[EXP_W-1:0], frac3};
            end
        end
    end

    logic [W-1:0] result_q;
    logic         ovf_q, unf_q;
`ifdef FPU_MUL_INF_NAN_EN
    logic         inv_q;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
`ifdef FPU_MUL_INF_NAN_EN
            inv_q       <= 1'b0;
`endif
        end else if (en_o) begin
            out_valid_q <= v3;
            if (v3) begin
                result_q <= res_c;
                ovf_q    <= ovf_c;
                unf_q    <= unf_c;
`ifdef FPU_MUL_INF_NAN_EN
                inv_q    <= inv_c;
`endif
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`ifdef FPU_MUL_INF_NAN_EN
    assign bus.invalid   = inv_q;
`else
    assign bus.invalid   = 1'b0;
`endif
endmodule
